// File: rtl/led_pattern_engine.sv
// led_pattern_engine: button-driven LED pattern generator (rotate, bounce, fill, hold).
// Ports: clk/rst_n (async active-low); key_mode, key_dir raw buttons (1 = pressed);
//        leds = pattern drive (polarity per ACTIVE_LOW); mode (0..3) and dir registered.
module led_pattern_engine #(
  parameter int LED_WIDTH       = 8,
  parameter int TICK_DIV        = 12_500_000,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_mode,
  input  logic                 key_dir,
  output logic [LED_WIDTH-1:0] leds,
  output logic [1:0]           mode,
  output logic                 dir
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int K_MODE = 0;
  localparam int K_DIR  = 1;

  localparam logic [LED_WIDTH-1:0] LSB_ONE = {{(LED_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LED_WIDTH-1:0] MSB_ONE = {1'b1, {(LED_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    M_ROTATE = 2'd0,
    M_BOUNCE = 2'd1,
    M_FILL   = 2'd2,
    M_HOLD   = 2'd3
  } mode_t;

  // ---------------------------------------------------------------
  // Key conditioning: 2-flop sync, counter debounce, press pulse
  // ---------------------------------------------------------------
  logic [1:0]    keys;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  assign keys = {key_dir, key_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      press <= '0;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] == deb[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          // Level accepted on the DEBOUNCE_CYCLES-th differing sample;
          // the press pulse is raised in the same cycle as a 0->1 acceptance.
          db_cnt[k] <= '0;
          deb[k]    <= sync2[k];
          press[k]  <= sync2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Pattern state machine
  // ---------------------------------------------------------------
  mode_t                mode_q, mode_d;
  logic                 dir_q, dir_d;
  logic [LED_WIDTH-1:0] p_q, p_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 strobe;
  logic                 new_dir;
  logic                 bdir;
  logic [LED_WIDTH-1:0] rot_up;
  logic [LED_WIDTH-1:0] rot_dn;

  assign strobe  = (tick_q == TW'(TICK_DIV - 1));
  assign new_dir = dir_q ^ press[K_DIR];
  assign rot_up  = {p_q[LED_WIDTH-2:0], p_q[LED_WIDTH-1]};
  assign rot_dn  = {p_q[0], p_q[LED_WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= M_ROTATE;
      dir_q  <= 1'b0;
      p_q    <= LSB_ONE;
      tick_q <= '0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      p_q    <= p_d;
      tick_q <= tick_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    dir_d  = new_dir;
    p_d    = p_q;
    tick_d = strobe ? '0 : tick_q + TW'(1);
    bdir   = new_dir;

    if (press[K_MODE]) begin
      // A mode press overrides any step in the same cycle.
      mode_d = mode_t'(mode_q + 2'd1);
      tick_d = '0;
      case (mode_d)
        M_ROTATE, M_BOUNCE: p_d = new_dir ? MSB_ONE : LSB_ONE;
        M_FILL:             p_d = '0;
        default:            p_d = p_q;
      endcase
    end else if (strobe) begin
      case (mode_q)
        M_ROTATE: p_d = new_dir ? rot_dn : rot_up;
        M_BOUNCE: begin
          // End reversal only when no dir press competes this cycle.
          if (!press[K_DIR]) begin
            if (!dir_q && p_q[LED_WIDTH-1])
              bdir = 1'b1;
            else if (dir_q && p_q[0])
              bdir = 1'b0;
          end
          dir_d = bdir;
          p_d   = bdir ? rot_dn : rot_up;
        end
        M_FILL: begin
          if (&p_q)
            p_d = '0;
          else if (new_dir)
            p_d = {1'b1, p_q[LED_WIDTH-1:1]};
          else
            p_d = {p_q[LED_WIDTH-2:0], 1'b1};
        end
        default: p_d = p_q;
      endcase
    end
  end

  assign leds = ACTIVE_LOW ? ~p_q : p_q;
  assign mode = mode_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed self-checking bench for led_pattern_engine.
// Runs with LED_WIDTH=4, TICK_DIV=3, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode;
  logic       key_dir;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       dir;

  int total = 0;
  int bad   = 0;

  led_pattern_engine #(
    .LED_WIDTH(4),
    .TICK_DIV(3),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_mode(key_mode),
    .key_dir(key_dir),
    .leds(leds),
    .mode(mode),
    .dir(dir)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Press a key and wait (bounded) for its effect on mode or dir.
  task automatic press_key(input bit is_mode);
    logic [1:0] old_m;
    logic       old_d;
    int         k;
    old_m = mode;
    old_d = dir;
    if (is_mode) key_mode = 1'b1;
    else         key_dir  = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((is_mode && mode === old_m) || (!is_mode && dir === old_d)) && k < 12);
    key_mode = 1'b0;
    key_dir  = 1'b0;
    total++;
    if (k < 6 || k > 8) begin
      bad++;
      $display("FAIL press_latency: got %0d cycles want 6..8", k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_mode = 1'b0; key_dir = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL reset_leds: got %b want 1110", leds); end
    total++; if (mode !== 2'd0)    begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
    total++; if (dir !== 1'b0)     begin bad++; $display("FAIL reset_dir: got %b want 0", dir); end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_p;
    rst_n = 1'b1;
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL rot_start: got %b want 1110", leds); end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      exp_p = 4'b0001 << ((i / 3) % 4);
      total++;
      if (leds !== ~exp_p) begin bad++; $display("FAIL rot_cycle%0d: got %b want %b", i, leds, ~exp_p); end
    end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL rot_mode: got %0d want 0", mode); end
    total++; if (dir !== 1'b0)  begin bad++; $display("FAIL rot_dir: got %b want 0", dir); end
  endtask

  task automatic test_dir_key();
    int         tog_at;
    int         toggles;
    int         k;
    logic       prev;
    logic [3:0] old_p;
    logic [3:0] cur;
    logic [3:0] exp_p;
    // 3-cycle glitch must be rejected
    key_dir = 1'b1;
    repeat (3) @(negedge clk);
    key_dir = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL dir_glitch: got %b want 0", dir); end
    // 10-cycle hold toggles once
    key_dir = 1'b1; tog_at = 0; toggles = 0; prev = dir;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 10) key_dir = 1'b0;
      if (dir !== prev) begin
        toggles++;
        if (tog_at == 0) tog_at = i;
        prev = dir;
      end
    end
    total++; if (tog_at < 6 || tog_at > 8) begin bad++; $display("FAIL dir_latency: got %0d want 6..8", tog_at); end
    total++; if (toggles != 1) begin bad++; $display("FAIL dir_toggles: got %0d want 1", toggles); end
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL dir_value: got %b want 1", dir); end
    // rotation now runs toward lower index
    for (int n = 0; n < 2; n++) begin
      old_p = ~leds;
      k = 0;
      cur = ~leds;
      while (cur === old_p && k < 4) begin
        @(negedge clk);
        k++;
        cur = ~leds;
      end
      exp_p = {old_p[0], old_p[3:1]};
      total++;
      if (cur !== exp_p) begin bad++; $display("FAIL rot_down%0d: got %b want %b", n, cur, exp_p); end
    end
    press_key(1'b0);
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL dir_restore: got %b want 0", dir); end
  endtask

  task automatic test_bounce();
    logic [3:0] seq_p [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       seq_d [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    press_key(1'b1);
    total++; if (mode !== 2'd1)    begin bad++; $display("FAIL bounce_mode: got %0d want 1", mode); end
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL bounce_entry: got %b want 1110", leds); end
    for (int s = 0; s < 7; s++) begin
      repeat (3) @(negedge clk);
      total++;
      if (leds !== ~seq_p[s]) begin bad++; $display("FAIL bounce_p%0d: got %b want %b", s, leds, ~seq_p[s]); end
      total++;
      if (dir !== seq_d[s]) begin bad++; $display("FAIL bounce_dir%0d: got %b want %b", s, dir, seq_d[s]); end
    end
  endtask

  task automatic test_fill();
    logic [3:0] up_p [3] = '{4'b0001, 4'b0011, 4'b0111};
    logic [3:0] dn_p [5] = '{4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};
    press_key(1'b1);
    total++; if (mode !== 2'd2)    begin bad++; $display("FAIL fill_mode: got %0d want 2", mode); end
    total++; if (leds !== 4'b1111) begin bad++; $display("FAIL fill_entry: got %b want 1111", leds); end
    for (int s = 0; s < 3; s++) begin
      repeat (3) @(negedge clk);
      total++;
      if (leds !== ~up_p[s]) begin bad++; $display("FAIL fill_up%0d: got %b want %b", s, leds, ~up_p[s]); end
    end
    // dir press timed to land right after the wrap to empty
    key_dir = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (leds !== 4'b0000) begin bad++; $display("FAIL fill_full: got %b want 0000", leds); end
    repeat (3) @(negedge clk);
    total++; if (leds !== 4'b1111) begin bad++; $display("FAIL fill_wrap: got %b want 1111", leds); end
    total++; if (dir !== 1'b0)     begin bad++; $display("FAIL fill_dir0: got %b want 0", dir); end
    @(negedge clk);
    key_dir = 1'b0;
    total++; if (dir !== 1'b1)     begin bad++; $display("FAIL fill_dir1: got %b want 1", dir); end
    total++; if (leds !== 4'b1111) begin bad++; $display("FAIL fill_noreload: got %b want 1111", leds); end
    repeat (2) @(negedge clk);
    total++; if (leds !== 4'b0111) begin bad++; $display("FAIL fill_dn_first: got %b want 0111", leds); end
    for (int s = 0; s < 5; s++) begin
      repeat (3) @(negedge clk);
      total++;
      if (leds !== ~dn_p[s]) begin bad++; $display("FAIL fill_dn%0d: got %b want %b", s, leds, ~dn_p[s]); end
    end
  endtask

  task automatic test_hold();
    press_key(1'b1);
    total++; if (mode !== 2'd3)    begin bad++; $display("FAIL hold_mode: got %0d want 3", mode); end
    total++; if (leds !== 4'b0001) begin bad++; $display("FAIL hold_entry: got %b want 0001", leds); end
    for (int i = 0; i < 6; i++) begin
      repeat (5) @(negedge clk);
      total++;
      if (leds !== 4'b0001) begin bad++; $display("FAIL hold_frozen%0d: got %b want 0001", i, leds); end
    end
    press_key(1'b0);
    total++; if (dir !== 1'b0)     begin bad++; $display("FAIL hold_dir: got %b want 0", dir); end
    total++; if (leds !== 4'b0001) begin bad++; $display("FAIL hold_dir_p: got %b want 0001", leds); end
    repeat (10) @(negedge clk);
    total++; if (leds !== 4'b0001) begin bad++; $display("FAIL hold_after_dir: got %b want 0001", leds); end
    press_key(1'b1);
    total++; if (mode !== 2'd0)    begin bad++; $display("FAIL hold_exit_mode: got %0d want 0", mode); end
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL hold_exit_p: got %b want 1110", leds); end
  endtask

  task automatic test_back_to_back();
    // mode press lands on a step strobe
    repeat (11) @(negedge clk);
    total++; if (leds !== 4'b0111) begin bad++; $display("FAIL pre_coincide: got %b want 0111", leds); end
    press_key(1'b1);
    total++; if (mode !== 2'd1)    begin bad++; $display("FAIL coincide_mode: got %0d want 1", mode); end
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL coincide_reload: got %b want 1110", leds); end
    @(negedge clk);
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL coincide_c1: got %b want 1110", leds); end
    @(negedge clk);
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL coincide_c2: got %b want 1110", leds); end
    @(negedge clk);
    total++; if (leds !== 4'b1101) begin bad++; $display("FAIL coincide_c3: got %b want 1101", leds); end
    // into FILL with dir=1 after a bounce reversal, then async reset
    repeat (9) @(negedge clk);
    press_key(1'b1);
    total++; if (mode !== 2'd2) begin bad++; $display("FAIL mid_fill_mode: got %0d want 2", mode); end
    total++; if (dir !== 1'b1)  begin bad++; $display("FAIL mid_fill_dir: got %b want 1", dir); end
    repeat (6) @(negedge clk);
    total++; if (leds !== 4'b0011) begin bad++; $display("FAIL mid_fill_p: got %b want 0011", leds); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (leds !== 4'b1110) begin bad++; $display("FAIL areset_leds: got %b want 1110", leds); end
    total++; if (mode !== 2'd0)    begin bad++; $display("FAIL areset_mode: got %0d want 0", mode); end
    total++; if (dir !== 1'b0)     begin bad++; $display("FAIL areset_dir: got %b want 0", dir); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_dir_key();
    test_bounce();
    test_fill();
    test_hold();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
